// File: rtl/lsu_arb.sv
// lsu_arb: round-robin arbiter sharing one LSU port between the core (m0)
// and a debug/DMA loader (m1), with bounded burst lock and access checks.
module lsu_arb #(
    parameter int unsigned MAX_LOCK = 16,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_be,
    input  logic [31:0]       m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_be,
    input  logic [31:0]       m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,

    output logic              lsu_st_en,
    output logic [ADDR_W-1:0] lsu_addr,
    output logic [3:0]        lsu_byte_en,
    output logic [31:0]       lsu_st_data,
    input  logic [31:0]       lsu_ld_data
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    localparam logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(32'h900);
    localparam logic [ADDR_W-1:0] MAP_TOP  = ADDR_W'(32'hA00);
    localparam logic [CNT_W-1:0]  LOCK_MAX = CNT_W'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_M0,
        OWN_M1
    } owner_e;

    owner_e           owner_q;
    owner_e           owner_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] run;
    logic             rr_q;
    logic             rr_d;

    logic             legal0;
    logic             legal1;
    logic             any_gnt;
    logic             sel;
    logic             sel_lock;
    owner_e           sel_own;

    logic             rv0_q;
    logic             rv1_q;
    logic             err0_q;
    logic             err1_q;
    logic [31:0]      rd0_q;
    logic [31:0]      rd1_q;

    // Unmapped space rejects everything; the switch-input window rejects stores.
    function automatic logic is_legal(
        input logic              we,
        input logic [ADDR_W-1:0] a
    );
        logic unmapped;
        logic in_region;
        unmapped  = (a >= MAP_TOP);
        in_region = (a >= IN_BASE) && (a < MAP_TOP);
        return !unmapped && !(we && in_region);
    endfunction

    assign legal0 = is_legal(m0_we, m0_addr);
    assign legal1 = is_legal(m1_we, m1_addr);

    // Lock owner first, then a lone requester, then rr_q breaks a tie.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst_i) begin
            if (owner_q == OWN_M0 && m0_req) begin
                m0_gnt = 1'b1;
            end else if (owner_q == OWN_M1 && m1_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req && m1_req) begin
                m0_gnt = !rr_q;
                m1_gnt = rr_q;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    always_comb begin
        lsu_st_en   = 1'b0;
        lsu_addr    = '0;
        lsu_byte_en = '0;
        lsu_st_data = '0;
        if (m0_gnt) begin
            lsu_st_en   = m0_we && legal0;
            lsu_addr    = m0_addr;
            lsu_byte_en = m0_be;
            lsu_st_data = m0_wdata;
        end else if (m1_gnt) begin
            lsu_st_en   = m1_we && legal1;
            lsu_addr    = m1_addr;
            lsu_byte_en = m1_be;
            lsu_st_data = m1_wdata;
        end
    end

    assign any_gnt  = m0_gnt || m1_gnt;
    assign sel      = m1_gnt;
    assign sel_lock = sel ? m1_lock : m0_lock;
    assign sel_own  = sel ? OWN_M1 : OWN_M0;
    assign run      = (owner_q == sel_own) ? cnt_q : '0;

    // A lock survives only while its owner keeps being granted with lock set.
    always_comb begin
        owner_d = OWN_NONE;
        cnt_d   = '0;
        rr_d    = rr_q;
        if (any_gnt) begin
            rr_d = !sel;
            if (sel_lock && run != LOCK_MAX) begin
                owner_d = sel_own;
                cnt_d   = run + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            rv0_q   <= m0_gnt;
            rv1_q   <= m1_gnt;
            err0_q  <= m0_gnt && !legal0;
            err1_q  <= m1_gnt && !legal1;
            rd0_q   <= (m0_gnt && legal0 && !m0_we) ? lsu_ld_data : '0;
            rd1_q   <= (m1_gnt && legal1 && !m1_we) ? lsu_ld_data : '0;
        end
    end

    // Responses are suppressed while reset is held so a pending one is dropped.
    assign m0_rvalid = rv0_q && !rst_i;
    assign m1_rvalid = rv1_q && !rst_i;
    assign m0_err    = err0_q && !rst_i;
    assign m1_err    = err1_q && !rst_i;
    assign m0_rdata  = rst_i ? '0 : rd0_q;
    assign m1_rdata  = rst_i ? '0 : rd1_q;

endmodule

// File: tb/tb_lsu_arb.sv
// tb_lsu_arb: directed and randomized checks of lsu_arb against a
// behavioural arbitration/memory model.
module tb_lsu_arb;

    localparam int MAX_LOCK = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req[2];
    logic        we[2];
    logic        lock[2];
    logic [11:0] addr[2];
    logic [3:0]  be[2];
    logic [31:0] wd[2];

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        lsu_st_en;
    logic [11:0] lsu_addr;
    logic [3:0]  lsu_byte_en;
    logic [31:0] lsu_st_data;
    logic [31:0] lsu_ld_data;

    lsu_arb dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_be(be[0]),
        .m0_wdata(wd[0]), .m0_lock(lock[0]), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_be(be[1]),
        .m1_wdata(wd[1]), .m1_lock(lock[1]), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .lsu_st_en(lsu_st_en), .lsu_addr(lsu_addr), .lsu_byte_en(lsu_byte_en),
        .lsu_st_data(lsu_st_data), .lsu_ld_data(lsu_ld_data)
    );

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // LSU stand-in: word memory driven by the DUT's LSU port.
    bit [31:0] mem[1024];
    assign lsu_ld_data = mem[lsu_addr[11:2]];
    always @(posedge clk)
        if (lsu_st_en) mem[lsu_addr[11:2]] <= merge(mem[lsu_addr[11:2]], lsu_st_data, lsu_byte_en);

    // Reference model state
    int          owner = -1;
    int          run = 0;
    int          rr = 0;
    bit          pv[2];
    bit          pe[2];
    logic [31:0] prd[2];
    bit [31:0]   mm[1024];
    int          model_g;

    int checks = 0;
    int failures = 0;
    int glog[$];
    logic        o_st_en, o_rv0, o_rv1, o_err0, o_err1;
    logic [31:0] o_rd0, o_rd1;
    logic [11:0] o_addr;
    logic [3:0]  o_be;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(logic w, logic [11:0] a);
        if (a >= 12'hA00) return 1'b0;
        if (w && a >= 12'h900) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int pick();
        if (rst) return -1;
        if (owner >= 0 && req[owner]) return owner;
        if (req[0] && req[1]) return rr;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic step();
        int g;
        bit lg;
        int r;
        @(negedge clk);
        g  = pick();
        lg = (g >= 0) ? legal(we[g], addr[g]) : 1'b0;
        chk("m0_gnt", m0_gnt, g == 0);
        chk("m1_gnt", m1_gnt, g == 1);
        chk("m0_rvalid", m0_rvalid, pv[0] && !rst);
        chk("m1_rvalid", m1_rvalid, pv[1] && !rst);
        chk("m0_err", m0_err, pv[0] && pe[0] && !rst);
        chk("m1_err", m1_err, pv[1] && pe[1] && !rst);
        chk("m0_rdata", m0_rdata, rst ? 32'h0 : prd[0]);
        chk("m1_rdata", m1_rdata, rst ? 32'h0 : prd[1]);
        chk("lsu_st_en", lsu_st_en, g >= 0 && we[g] && lg);
        chk("lsu_addr", lsu_addr, g >= 0 ? addr[g] : 12'h0);
        chk("lsu_byte_en", lsu_byte_en, g >= 0 ? be[g] : 4'h0);
        chk("lsu_st_data", lsu_st_data, g >= 0 ? wd[g] : 32'h0);
        glog.push_back(m0_gnt ? 0 : (m1_gnt ? 1 : -1));
        o_st_en = lsu_st_en; o_addr = lsu_addr; o_be = lsu_byte_en;
        o_rv0 = m0_rvalid; o_err0 = m0_err; o_rd0 = m0_rdata;
        o_rv1 = m1_rvalid; o_err1 = m1_err; o_rd1 = m1_rdata;
        model_g = g;
        if (rst) begin
            owner = -1; run = 0; rr = 0;
            for (int x = 0; x < 2; x++) begin pv[x] = 0; pe[x] = 0; prd[x] = 0; end
        end else begin
            for (int x = 0; x < 2; x++) begin
                pv[x]  = (g == x);
                pe[x]  = (g == x) && !lg;
                prd[x] = (g == x && lg && !we[x]) ? mm[addr[x][11:2]] : 32'h0;
            end
            if (g >= 0) begin
                r  = (owner == g) ? run : 0;
                rr = 1 - g;
                if (lock[g] && r < MAX_LOCK - 1) begin owner = g; run = r + 1; end
                else begin owner = -1; run = 0; end
                if (we[g] && lg) mm[addr[g][11:2]] = merge(mm[addr[g][11:2]], wd[g], be[g]);
            end else begin
                owner = -1; run = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(int x, bit r, bit w, logic [11:0] a, logic [3:0] b, logic [31:0] d, bit l);
        req[x] = r; we[x] = w; addr[x] = a; be[x] = b; wd[x] = d; lock[x] = l;
    endtask

    task automatic idle();
        set_m(0, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        set_m(1, 0, 0, 12'h0, 4'h0, 32'h0, 0);
    endtask

    task automatic do_reset();
        rst = 1; idle(); step(); rst = 0;
    endtask

    function automatic logic [11:0] raddr();
        case ($urandom_range(0, 7))
            0: return 12'h010;
            1: return 12'h8FC;
            2: return 12'h900;
            3: return 12'h9FF;
            4: return 12'hA00;
            5: return 12'hFFF;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    initial begin
        int n;
        for (int x = 0; x < 2; x++) begin pv[x] = 0; pe[x] = 0; prd[x] = 0; end
        do_reset();
        chk("reset_st_en", o_st_en, 0);
        chk("reset_rv0", o_rv0, 0);

        // store then load
        set_m(0, 1, 1, 12'h010, 4'hF, 32'hDEADBEEF, 0);
        step();
        chk("sl_gnt_store", glog[glog.size()-1], 0);
        chk("sl_st_en_store", o_st_en, 1);
        set_m(0, 1, 0, 12'h010, 4'h0, 32'h0, 0);
        step();
        chk("sl_st_en_load", o_st_en, 0);
        chk("sl_rv_store", o_rv0, 1);
        idle();
        step();
        chk("sl_rv_load", o_rv0, 1);
        chk("sl_rdata", o_rd0, 32'hDEADBEEF);
        chk("sl_err", o_err0, 0);

        // contention from reset
        do_reset();
        set_m(0, 1, 0, 12'h010, 4'h0, 32'h0, 0);
        set_m(1, 1, 0, 12'h014, 4'h0, 32'h0, 0);
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 4; i++) chk("rr_order", glog[glog.size()-4+i], i % 2);

        // lock limit
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_m(0, i >= 1, 0, 12'h020, 4'h0, 32'h0, 0);
            set_m(1, 1, 0, 12'h024, 4'h0, 32'h0, i < 16);
            step();
        end
        for (int i = 0; i < 20; i++)
            chk("lock_seq", glog[glog.size()-20+i], (i < 16) ? 1 : ((i % 2 == 0) ? 0 : 1));

        // illegal accesses
        do_reset();
        set_m(0, 1, 1, 12'h900, 4'hF, 32'h12345678, 0);
        step();
        chk("ill_gnt0", glog[glog.size()-1], 0);
        chk("ill_st_en", o_st_en, 0);
        idle();
        set_m(1, 1, 0, 12'hA04, 4'h0, 32'h0, 0);
        step();
        chk("ill_gnt1", glog[glog.size()-1], 1);
        chk("ill_rv0", o_rv0, 1);
        chk("ill_err0", o_err0, 1);
        chk("ill_rd0", o_rd0, 0);
        idle();
        step();
        chk("ill_rv1", o_rv1, 1);
        chk("ill_err1", o_err1, 1);
        chk("ill_rd1", o_rd1, 0);

        // I/O store
        set_m(1, 1, 1, 12'h880, 4'h1, 32'h0000007F, 0);
        step();
        chk("io_addr", o_addr, 12'h880);
        chk("io_be", o_be, 4'h1);
        chk("io_st_en", o_st_en, 1);
        idle();
        step();
        chk("io_rv1", o_rv1, 1);
        chk("io_err1", o_err1, 0);
        chk("io_st_en_after", o_st_en, 0);

        // reset during a pending response
        set_m(1, 1, 0, 12'h030, 4'h0, 32'h0, 0);
        step();
        set_m(1, 0, 0, 12'h0, 4'h0, 32'h0, 0);
        set_m(0, 1, 0, 12'h010, 4'h0, 32'h0, 0);
        step();
        rst = 1; idle();
        step();
        chk("mr_rv0", o_rv0, 0);
        chk("mr_rd0", o_rd0, 0);
        chk("mr_st_en", o_st_en, 0);
        rst = 0;
        set_m(0, 1, 0, 12'h010, 4'h0, 32'h0, 0);
        set_m(1, 1, 0, 12'h014, 4'h0, 32'h0, 0);
        step();
        chk("mr_first", glog[glog.size()-1], 0);

        // randomized traffic
        idle();
        n = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int x = 0; x < 2; x++) begin
                if (!rst && (!req[x] || model_g == x)) begin
                    if ($urandom_range(0, 9) < 7)
                        set_m(x, 1, 1'($urandom_range(0, 1)), raddr(),
                              4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);
                    else
                        set_m(x, 0, 0, 12'h0, 4'h0, 32'h0, 0);
                end
            end
            step();
            if (model_g >= 0) n++;
        end
        chk("rand_activity", n > 1000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_arb.md
Name: lsu_arb

Overview:
- Two-master arbiter that shares the single load/store unit port (12-bit byte address, 4-bit byte enable, 32-bit store/load data) between the core data port (m0) and a debug/DMA loader port (m1).
- Issues at most one LSU access per cycle and returns a registered response one cycle later.
- Uses round-robin arbitration with an optional bounded lock for bursts.
- Rejects illegal accesses (unmapped addresses, writes to the switch-input region) without touching the LSU.

Parameters:
- MAX_LOCK, 16, maximum number of consecutive grants a locking master may hold before being forced to release.
- ADDR_W, 12, LSU byte-address width.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- m0_req, m1_req  in  1 each  access request; held high until granted.
- m0_we, m1_we  in  1 each  1 = store, 0 = load.
- m0_addr, m1_addr  in  ADDR_W each  byte address.
- m0_be, m1_be  in  4 each  byte enables for stores.
- m0_wdata, m1_wdata  in  32 each  store data.
- m0_lock, m1_lock  in  1 each  request to keep the grant on the next cycle.
- m0_gnt, m1_gnt  out  1 each  combinational grant; the access is consumed this cycle.
- m0_rvalid, m1_rvalid  out  1 each  registered response strobe, one cycle after grant.
- m0_rdata, m1_rdata  out  32 each  load data; 0 for stores and errors.
- m0_err, m1_err  out  1 each  access rejected; qualified by rvalid.
- lsu_st_en  out  1  store enable to the LSU.
- lsu_addr  out  ADDR_W  LSU address.
- lsu_byte_en  out  4  LSU byte enables.
- lsu_st_data  out  32  LSU store data.
- lsu_ld_data  in  32  LSU load data; valid before the rising edge that ends the grant cycle.

Behaviour:
- Reset: all rvalid, err and rdata outputs = 0; rr_ptr = m0; lock_owner = none; lock_cnt = 0. lsu_st_en = 0 in the reset cycle and in any cycle with no grant.
- Arbitration, cycle N:
  - If lock_owner = X and mX_req = 1, grant X.
  - Otherwise, if only one master requests, grant it.
  - If both request, grant the master selected by rr_ptr.
  - At most one gnt per cycle. A master with req = 0 is never granted.
- rr_ptr update: after any grant to X, rr_ptr = the other master (including locked grants).
- Lock:
  - On a grant to X with mX_lock = 1: lock_owner = X and lock_cnt increments.
  - Lock ends when X is granted with lock = 0, when X drops req, or when lock_cnt reaches MAX_LOCK-1 on a grant. In the last case lock_owner = none, lock_cnt = 0, and the other master wins the next contention.
  - With lock_owner = none, lock_cnt = 0.
- LSU drive: in the grant cycle, lsu_addr, lsu_byte_en and lsu_st_data come combinationally from the granted master. lsu_st_en = granted we AND legal. When idle, address/data/byte_en outputs = 0.
- Legality:
  - Address >= 0xA00 is illegal for both loads and stores.
  - A store to 0x900–0x9FF (the input region) is illegal.
  - All other accesses are legal. byte_en = 0 on a store is legal and is passed through unchanged.
- Illegal access: gnt still asserts (request consumed), lsu_st_en = 0. In cycle N+1: rvalid = 1, err = 1, rdata = 0.
- Response: in cycle N+1, mX_rvalid = 1 for exactly one cycle. rdata = lsu_ld_data captured at the rising edge ending cycle N for a legal load, otherwise 0. err = 0 for legal accesses. The non-granted master's rvalid = 0.
- Throughput: back-to-back grants are allowed every cycle. A response in N+1 and a new grant in N+1 may coexist.
- Reset asserted mid-operation: a pending response is dropped (rvalid = 0 next cycle), lock is cleared, and rr_ptr returns to m0.
- No combinational path from lsu_ld_data to any output.

Test Plan:
- Store then load: m0 stores 0xDEADBEEF, be = 0xF at 0x010; next cycle m0 loads 0x010. Expect two grants, lsu_st_en = 1 only in the first, m0_rvalid in cycles 2 and 3, rdata = 0xDEADBEEF in cycle 3, err = 0.
- Contention round-robin: both masters hold req (loads) for 4 cycles from reset. Expect grant order m0, m1, m0, m1, with each rvalid one cycle after its grant.
- Lock limit, MAX_LOCK = 16: m1 holds req and lock, m0 holds req. Expect m1 granted 16 consecutive cycles, then m0 granted in cycle 17, then alternation.
- Illegal accesses: m0 stores to 0x900; m1 loads from 0xA04. Expect gnt for each, lsu_st_en = 0, rvalid with err = 1 and rdata = 0.
- I/O store: m1 stores 0x7F to 0x880 with be = 0x1. Expect lsu_addr = 0x880, lsu_byte_en = 0x1, lsu_st_en = 1 for one cycle, then m1_rvalid with err = 0.
- Mid-operation reset: rst_i asserts in the cycle after an m0 load grant. Expect m0_rvalid = 0, all outputs 0, and after release a dual request grants m0 first.
